fetch_gate: RTL and testbench
=============================

Name: fetch_gate

Overview:
- Sits between one core's instruction-fetch port and its instruction memory. There is one instance per core copy in the two-copy contract-synthesis bench.
- While the instance is enabled, fetches pass through to memory, and each granted fetch is reported as a one-cycle pulse to the run controller.
- Once the controller drops the instance's enable, the block completes the in-flight memory reads, then answers every further fetch locally with a NOP. The core keeps running until its retirements reach the instruction limit.

Parameters:
- ADDR_W, 64, fetch address width.
- DATA_W, 32, fetch data width.
- MAX_OUTSTANDING, 2, maximum memory reads accepted but not yet answered.
- NOP_INSN, 32'h0000_0013, instruction returned after disable (`addi x0,x0,0`).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, reset synchronous active-high.
- enable_i  in  1  fetch enable from the run controller.
- core_req_i  in  1  core fetch request.
- core_addr_i  in  ADDR_W  core fetch address.
- core_gnt_o  out  1  request accepted.
- core_rvalid_o  out  1  response valid.
- core_rdata_o  out  DATA_W  response instruction.
- mem_req_o  out  1  memory request.
- mem_addr_o  out  ADDR_W  memory address, equal to core_addr_i.
- mem_gnt_i  in  1  memory grant.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  DATA_W  memory response data.
- fetch_o  out  1  one-cycle pulse per memory-granted fetch, to the controller's fetch input.
- drained_o  out  1  disabled, with no memory read outstanding.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset values: state PASS, outstanding count 0, fetch_o 0, drained_o 0, error_o 0, NOP response pending 0. Reset asserted mid-operation discards all state, including in-flight bookkeeping.
- States:
  - PASS: enabled.
  - DRAIN: disabled, count > 0.
  - NOPFEED: disabled, count = 0.
- Transitions:
  - PASS -> DRAIN when enable_i=0 and the count after this cycle's update is > 0.
  - PASS -> NOPFEED when enable_i=0 and that count is 0.
  - DRAIN -> NOPFEED when the count reaches 0.
  - Disable is sticky. enable_i returning to 1 is ignored until reset.
- Grant rules in PASS:
  - mem_req_o = core_req_i & enable_i & (count < MAX_OUTSTANDING), combinational.
  - core_gnt_o = mem_req_o & mem_gnt_i.
  - enable_i is sampled combinationally, so enable falling in the same cycle as mem_gnt_i produces no grant and no fetch pulse.
- Grant rules in DRAIN: mem_req_o=0 and core_gnt_o=0.
- Grant rules in NOPFEED:
  - mem_req_o=0.
  - core_gnt_o = core_req_i & ~nop_pending.
  - A local grant sets nop_pending. In the next cycle core_rvalid_o=1 with core_rdata_o=NOP_INSN, and nop_pending clears.
  - Throughput is one local grant every 2 cycles.
- Responses in PASS/DRAIN: core_rvalid_o=mem_rvalid_i and core_rdata_o=mem_rdata_i (combinational pass-through, order preserved). Memory responses never interleave with NOPs, because NOPFEED requires count 0.
- Outstanding count, width $clog2(MAX_OUTSTANDING+1):
  - +1 on a memory grant, -1 on mem_rvalid_i.
  - Simultaneous grant and response leaves the count unchanged.
  - A grant is never issued at MAX_OUTSTANDING.
- fetch_o:
  - Registered; high exactly one cycle, in the cycle after each memory grant.
  - Never pulses for NOP grants.
  - A full-cycle pulse, so it is safely sampled on the falling edge.
- drained_o: registered, 1 whenever the state is NOPFEED.
- error_o is set (sticky until reset) when:
  - mem_rvalid_i arrives with count 0 (the count stays 0, the response is dropped, core_rvalid_o=0), or
  - mem_rvalid_i arrives in NOPFEED.

Decomposition:
- Shared package fetch_gate_pkg:
  - state enum (PASS, DRAIN, NOPFEED);
  - NOP_INSN constant;
  - count-width function.
- Sub-module fetch_gate_ctr: saturating up/down outstanding counter with an underflow flag, which feeds error_o.

Test Plan:
- Enabled, memory grants immediately, rvalid 1 cycle later, 5 fetches -> 5 fetch_o pulses, each one cycle after its grant; core sees mem data in order; count returns to 0.
- Memory stalls rvalid with 2 reads outstanding (MAX_OUTSTANDING=2), core keeps requesting -> mem_req_o=0 until an rvalid arrives; no third grant.
- enable_i falls with 2 outstanding -> state DRAIN; no grants; both memory responses forwarded; NOPFEED and drained_o=1 one cycle after the last rvalid.
- In NOPFEED with core_req_i held high for 6 cycles -> 3 grants, 3 rvalids carrying 32'h0000_0013; fetch_o stays 0; mem_req_o stays 0.
- enable_i falls in the same cycle as mem_gnt_i with count 0 -> core_gnt_o=0, no fetch_o pulse, direct to NOPFEED; enable_i re-raised -> state stays NOPFEED.
- Stray mem_rvalid_i at count 0 -> error_o=1 and held; core_rvalid_o=0. Then rst_i for 1 cycle mid-DRAIN -> all outputs 0, state PASS.

Source files
------------

// File: rtl/fetch_gate_pkg.sv
// Shared types and constants for the fetch gate.
// State encoding, default NOP word and counter width helper.
package fetch_gate_pkg;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    DRAIN   = 2'd1,
    NOPFEED = 2'd2
  } state_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;

  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fetch_gate_if.sv
// Core fetch port plus instruction memory port.
// slave: the gate; master: core/memory side.
interface fetch_gate_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);

  logic              core_req_i;
  logic [ADDR_W-1:0] core_addr_i;
  logic              core_gnt_o;
  logic              core_rvalid_o;
  logic [DATA_W-1:0] core_rdata_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i,
    input  core_addr_i,
    output core_gnt_o,
    output core_rvalid_o,
    output core_rdata_o,
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i,
    output core_addr_i,
    input  core_gnt_o,
    input  core_rvalid_o,
    input  core_rdata_o,
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/fetch_gate_ctr.sv
// Saturating up/down outstanding-read counter.
// inc_i/dec_i in; cnt_o, cnt_nxt_o, underflow_o out.
module fetch_gate_ctr #(
  parameter int MAX = 2,
  parameter int W   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o,
  output logic         underflow_o
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;
  logic         w_uf;
  logic         w_dec;

  // A response with nothing outstanding is dropped,
  // even if a grant lands in the same cycle.
  assign w_uf  = dec_i & (r_cnt == '0);
  assign w_dec = dec_i & ~w_uf;

  always_comb begin
    w_nxt = r_cnt;
    unique case ({inc_i, w_dec})
      2'b10: begin
        if (r_cnt != W'(MAX)) begin
          w_nxt = r_cnt + W'(1);
        end
      end
      2'b01:   w_nxt = r_cnt - W'(1);
      default: w_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign cnt_o       = r_cnt;
  assign cnt_nxt_o   = w_nxt;
  assign underflow_o = w_uf;

endmodule

// File: rtl/fetch_gate.sv
// Gates core fetches to memory; after disable, drains then feeds NOPs.
// clk_i/rst_i/enable_i in; bus (slave); fetch_o/drained_o/error_o out.
module fetch_gate
  import fetch_gate_pkg::*;
#(
  parameter int ADDR_W          = 64,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(NOP_INSN_DEF)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  fetch_gate_if.slave  bus,
  output logic         fetch_o,
  output logic         drained_o,
  output logic         error_o
);

  localparam int CW = cnt_w(MAX_OUTSTANDING);

  state_e r_state;
  state_e w_state_nxt;

  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_uf;

  logic r_nop;
  logic r_fetch;
  logic r_drained;
  logic r_err;

  logic              w_mem_req;
  logic              w_mem_gnt;
  logic              w_nop_gnt;
  logic              w_gnt;
  logic              w_rvalid;
  logic [DATA_W-1:0] w_rdata;
  logic              w_err_set;

  fetch_gate_ctr #(
    .MAX (MAX_OUTSTANDING),
    .W   (CW)
  ) u_ctr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (w_mem_gnt),
    .dec_i       (bus.mem_rvalid_i),
    .cnt_o       (w_cnt),
    .cnt_nxt_o   (w_cnt_nxt),
    .underflow_o (w_uf)
  );

  assign w_mem_gnt = w_mem_req & bus.mem_gnt_i;

  always_comb begin
    w_mem_req = 1'b0;
    w_nop_gnt = 1'b0;
    w_gnt     = 1'b0;
    w_rvalid  = 1'b0;
    w_rdata   = bus.mem_rdata_i;
    unique case (r_state)
      PASS: begin
        w_mem_req = bus.core_req_i & enable_i
                  & (w_cnt < CW'(MAX_OUTSTANDING));
        w_gnt     = w_mem_req & bus.mem_gnt_i;
        w_rvalid  = bus.mem_rvalid_i & ~w_uf;
      end
      DRAIN: begin
        w_rvalid  = bus.mem_rvalid_i & ~w_uf;
      end
      NOPFEED: begin
        // One local grant, answered next cycle.
        w_nop_gnt = bus.core_req_i & ~r_nop;
        w_gnt     = w_nop_gnt;
        w_rvalid  = r_nop;
        w_rdata   = NOP_INSN;
      end
      default: begin
        w_mem_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      PASS: begin
        if (!enable_i) begin
          w_state_nxt = (w_cnt_nxt != '0) ? DRAIN
                                          : NOPFEED;
        end
      end
      DRAIN: begin
        if (w_cnt_nxt == '0) begin
          w_state_nxt = NOPFEED;
        end
      end
      NOPFEED: w_state_nxt = NOPFEED;
      default: w_state_nxt = PASS;
    endcase
  end

  assign w_err_set = w_uf
                   | ((r_state == NOPFEED) & bus.mem_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= PASS;
      r_nop     <= 1'b0;
      r_fetch   <= 1'b0;
      r_drained <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_nop     <= w_nop_gnt;
      r_fetch   <= w_mem_gnt;
      r_drained <= (w_state_nxt == NOPFEED);
      r_err     <= r_err | w_err_set;
    end
  end

  assign bus.mem_req_o     = w_mem_req;
  assign bus.mem_addr_o    = bus.core_addr_i;
  assign bus.core_gnt_o    = w_gnt;
  assign bus.core_rvalid_o = w_rvalid;
  assign bus.core_rdata_o  = w_rdata;

  assign fetch_o   = r_fetch;
  assign drained_o = r_drained;
  assign error_o   = r_err;

endmodule

// File: tb/tb_fetch_gate.sv
// Self-checking bench for fetch_gate.
// Table vectors, directed sequences, response scoreboard.
module tb_fetch_gate;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic fetch;
  logic drained;
  logic err;

  fetch_gate_if #(.ADDR_W(64), .DATA_W(32)) bus ();

  fetch_gate #(
    .ADDR_W          (64),
    .DATA_W          (32),
    .MAX_OUTSTANDING (2),
    .NOP_INSN        (32'h0000_0013)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .enable_i  (en),
    .bus       (bus),
    .fetch_o   (fetch),
    .drained_o (drained),
    .error_o   (err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic rq;
    logic e;
    logic g;
    logic x_mreq;
    logic x_gnt;
    logic x_fetch;
    logic x_drn;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Falling-edge sample point; scoreboard pops here.
  task automatic half();
    @(negedge clk);
    if (bus.core_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_rvalid", 64'(bus.core_rvalid_o), 0);
      end else begin
        chk("sb_data", 64'(bus.core_rdata_o), 64'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [63:0] a,
                       input logic e, input logic g,
                       input logic rv, input logic [31:0] d);
    bus.core_req_i   = rq;
    bus.core_addr_i  = a;
    en               = e;
    bus.mem_gnt_i    = g;
    bus.mem_rvalid_i = rv;
    bus.mem_rdata_i  = d;
    if (rv) exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 1, 0, 0, 0);
    adv();
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ng;
    tv[0] = '{1, 1, 1, 1, 1, 1, 0};
    tv[1] = '{1, 1, 0, 1, 0, 0, 0};
    tv[2] = '{0, 1, 1, 0, 0, 0, 0};
    tv[3] = '{1, 0, 1, 0, 0, 0, 1};
    tv[4] = '{0, 0, 0, 0, 0, 0, 1};

    // Reset state
    do_reset();
    half();
    chk("rst_fetch", 64'(fetch), 0);
    chk("rst_drained", 64'(drained), 0);
    chk("rst_error", 64'(err), 0);
    chk("rst_rvalid", 64'(bus.core_rvalid_o), 0);
    chk("rst_mreq", 64'(bus.mem_req_o), 0);
    adv();

    // Five back-to-back fetches, rvalid one cycle later
    for (int i = 0; i < 7; i++) begin
      drive(i < 5, 64'h1000 + 64'(4 * i), 1, i < 5,
            (i > 0) && (i < 6), 32'hC0DE_0000 + 32'(i));
      half();
      chk("t1_gnt", 64'(bus.core_gnt_o), 64'(i < 5));
      chk("t1_fetch", 64'(fetch), 64'((i > 0) && (i < 6)));
      if (i < 5) begin
        chk("t1_maddr", bus.mem_addr_o, 64'h1000 + 64'(4 * i));
      end
      adv();
    end

    // Stall with two outstanding
    for (int i = 0; i < 2; i++) begin
      drive(1, 64'h2000 + 64'(4 * i), 1, 1, 0, 0);
      half();
      chk("t2_mreq", 64'(bus.mem_req_o), 1);
      chk("t2_gnt", 64'(bus.core_gnt_o), 1);
      adv();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 64'h2008, 1, 1, 0, 0);
      half();
      chk("t2_full_mreq", 64'(bus.mem_req_o), 0);
      chk("t2_full_gnt", 64'(bus.core_gnt_o), 0);
      adv();
    end
    drive(1, 64'h2008, 1, 1, 1, 32'h2000_AAAA);
    half();
    chk("t2_rv_mreq", 64'(bus.mem_req_o), 0);
    adv();
    drive(1, 64'h2008, 1, 1, 0, 0);
    half();
    chk("t2_regnt", 64'(bus.core_gnt_o), 1);
    adv();

    // Disable with two outstanding -> DRAIN
    drive(1, 64'h200C, 0, 1, 0, 0);
    half();
    chk("t3_mreq", 64'(bus.mem_req_o), 0);
    chk("t3_gnt", 64'(bus.core_gnt_o), 0);
    chk("t3_fetch", 64'(fetch), 1);
    chk("t3_drn0", 64'(drained), 0);
    adv();
    drive(1, 64'h200C, 0, 1, 1, 32'h2000_BBBB);
    half();
    chk("t3_dgnt", 64'(bus.core_gnt_o), 0);
    chk("t3_dfetch", 64'(fetch), 0);
    chk("t3_drn1", 64'(drained), 0);
    adv();
    drive(1, 64'h200C, 0, 1, 1, 32'h2000_CCCC);
    half();
    chk("t3_dgnt2", 64'(bus.core_gnt_o), 0);
    chk("t3_drn2", 64'(drained), 0);
    adv();

    // NOPFEED, request held six cycles
    ng = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1, 64'h3000, 0, 0, 0, 0);
      if (k % 2 == 0) exp_q.push_back(NOP);
      half();
      if (bus.core_gnt_o === 1'b1) ng++;
      chk("t4_drained", 64'(drained), 1);
      chk("t4_gnt", 64'(bus.core_gnt_o), 64'(k % 2 == 0));
      chk("t4_rvalid", 64'(bus.core_rvalid_o), 64'(k % 2 == 1));
      chk("t4_mreq", 64'(bus.mem_req_o), 0);
      chk("t4_fetch", 64'(fetch), 0);
      adv();
    end
    drive(0, 0, 0, 0, 0, 0);
    half();
    chk("t4_ngnt", 64'(ng), 3);
    chk("t4_rv_end", 64'(bus.core_rvalid_o), 0);
    chk("t4_sb_empty", 64'(exp_q.size()), 0);
    adv();

    // Disable coincident with mem grant at count 0
    do_reset();
    drive(1, 64'h4000, 0, 1, 0, 0);
    half();
    chk("t5_gnt", 64'(bus.core_gnt_o), 0);
    chk("t5_mreq", 64'(bus.mem_req_o), 0);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    half();
    chk("t5_fetch", 64'(fetch), 0);
    chk("t5_drained", 64'(drained), 1);
    adv();
    drive(1, 64'h4004, 1, 1, 0, 0);
    exp_q.push_back(NOP);
    half();
    chk("t5_re_mreq", 64'(bus.mem_req_o), 0);
    chk("t5_re_gnt", 64'(bus.core_gnt_o), 1);
    chk("t5_re_drn", 64'(drained), 1);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    half();
    chk("t5_nop_rv", 64'(bus.core_rvalid_o), 1);
    chk("t5_nop_fetch", 64'(fetch), 0);
    chk("t5_err0", 64'(err), 0);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    half();
    chk("t5_stray_rv", 64'(bus.core_rvalid_o), 0);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    half();
    chk("t5_err", 64'(err), 1);
    adv();

    // Stray rvalid at count 0 in PASS, then reset mid-DRAIN
    do_reset();
    half();
    chk("t6_err0", 64'(err), 0);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h5555_5555;
    half();
    chk("t6_stray_rv", 64'(bus.core_rvalid_o), 0);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    half();
    chk("t6_err", 64'(err), 1);
    adv();
    half();
    chk("t6_err_hold", 64'(err), 1);
    adv();
    drive(1, 64'h5000, 1, 1, 0, 0);
    half();
    chk("t6_gnt", 64'(bus.core_gnt_o), 1);
    adv();
    drive(0, 0, 0, 0, 0, 0);
    half();
    chk("t6_fetch", 64'(fetch), 1);
    adv();
    half();
    chk("t6_drain", 64'(drained), 0);
    chk("t6_dr_err", 64'(err), 1);
    adv();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    adv();
    rst = 1'b0;
    exp_q.delete();
    drive(0, 0, 1, 0, 0, 0);
    half();
    chk("t6_r_fetch", 64'(fetch), 0);
    chk("t6_r_drn", 64'(drained), 0);
    chk("t6_r_err", 64'(err), 0);
    chk("t6_r_rv", 64'(bus.core_rvalid_o), 0);
    adv();
    drive(1, 64'h5004, 1, 1, 0, 0);
    half();
    chk("t6_pass_mreq", 64'(bus.mem_req_o), 1);
    chk("t6_pass_gnt", 64'(bus.core_gnt_o), 1);
    adv();
    drive(0, 0, 1, 0, 1, 32'h5004_0001);
    half();
    chk("t6_pass_fetch", 64'(fetch), 1);
    chk("t6_pass_rv", 64'(bus.core_rvalid_o), 1);
    adv();
    drive(0, 0, 1, 0, 0, 0);
    half();
    chk("t6_pass_err", 64'(err), 0);
    adv();

    // Single-cycle grant table from a fresh reset
    for (int i = 0; i < 5; i++) begin
      do_reset();
      drive(tv[i].rq, 64'h6000, tv[i].e, tv[i].g, 0, 0);
      half();
      chk("tv_mreq", 64'(bus.mem_req_o), 64'(tv[i].x_mreq));
      chk("tv_gnt", 64'(bus.core_gnt_o), 64'(tv[i].x_gnt));
      adv();
      drive(0, 0, tv[i].e, 0, 0, 0);
      half();
      chk("tv_fetch", 64'(fetch), 64'(tv[i].x_fetch));
      chk("tv_drained", 64'(drained), 64'(tv[i].x_drn));
      adv();
    end

    chk("sb_final_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
